// File: rtl/cdc_pkg.sv
// Shared types and constants for the receive-side CDC capture bank.
package cdc_pkg;

    typedef enum logic {CH_EMPTY = 1'b0, CH_FULL = 1'b1} ch_state_t;

    localparam int MIN_SYNC_STAGES = 2;

    localparam int MODE_LEVEL  = 0;
    localparam int MODE_TOGGLE = 1;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchroniser, chain reset to 0.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_vld_sync_rx.sv
// Multi-channel vld-qualified CDC capture bank with valid/ready output and overflow detect.
// Optional saturating overflow counters: define CDC_RX_OVF_CNT_EN.
module cdc_vld_sync_rx
    import cdc_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_MODE  = 0,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    di_vld,
    input  logic [NCH*DW-1:0] di_data,
    input  logic [NCH-1:0]    do_rdy,
    output logic [NCH-1:0]    do_vld,
    output logic [NCH*DW-1:0] do_data,
    output logic [NCH-1:0]    ovf,
    input  logic [NCH-1:0]    ovf_clr
`ifdef CDC_RX_OVF_CNT_EN
    ,
    output logic [NCH*CNT_W-1:0] ovf_cnt
`endif
);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("cdc_vld_sync_rx: SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("cdc_vld_sync_rx: CNT_W must be >= 1");
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic          s, prev, ev, drop;
        logic          vld_q, ovf_q;
        logic [DW-1:0] data_q;
        ch_state_t     state;

        cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (di_vld[c]),
            .q   (s)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) prev <= 1'b0;
            else     prev <= s;
        end

        assign ev   = (PULSE_MODE == MODE_TOGGLE) ? (s ^ prev) : (s & ~prev);
        assign drop = (state == CH_FULL) & ev & ~do_rdy[c];

        // di_data is captured directly: the source holds it stable until acceptance.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= CH_EMPTY;
                vld_q  <= 1'b0;
                data_q <= '0;
            end else begin
                case (state)
                    CH_EMPTY: begin
                        if (ev) begin
                            state  <= CH_FULL;
                            vld_q  <= 1'b1;
                            data_q <= di_data[c*DW +: DW];
                        end
                    end
                    CH_FULL: begin
                        if (ev) begin
                            if (do_rdy[c]) data_q <= di_data[c*DW +: DW];
                        end else if (do_rdy[c]) begin
                            state <= CH_EMPTY;
                            vld_q <= 1'b0;
                        end
                    end
                    default: begin
                        state <= CH_EMPTY;
                        vld_q <= 1'b0;
                    end
                endcase
            end
        end

        // A new drop wins over a clear in the same cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)             ovf_q <= 1'b0;
            else if (drop)       ovf_q <= 1'b1;
            else if (ovf_clr[c]) ovf_q <= 1'b0;
        end

        assign do_vld[c]           = vld_q;
        assign do_data[c*DW +: DW] = data_q;
        assign ovf[c]              = ovf_q;

`ifdef CDC_RX_OVF_CNT_EN
        localparam logic [CNT_W-1:0] CNT_MAX = '1;
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst)                          cnt_q <= '0;
            else if (ovf_clr[c])              cnt_q <= drop ? CNT_W'(1) : '0;
            else if (drop && cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
        end

        assign ovf_cnt[c*CNT_W +: CNT_W] = cnt_q;
`endif
    end

endmodule
